instr_fetch: RTL and testbench

Instruction fetch unit for the 16-bit single-issue MIPS-style core. It drives the instruction-memory request port, buffers returned instruction words with their PCs, and presents them to the decode stage, exposing the 3-bit opcode that `control_signal` consumes. It is the producing end of the opcode interface. Jump and branch resolution feed back as a redirect that flushes in-flight work.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit MIPS-style core:
// widths, opcode encodings, fetch FSM states.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  function automatic logic [2:0] opcode_of(
    input logic [INSTR_W-1:0] instr
  );
    return instr[INSTR_W-1:INSTR_W-3];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x WIDTH synchronous FIFO.
// Ports: push/din, pop/dout, flush (beats push), full, empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a full buffer still takes a word if one leaves
  assign do_push = push && (!full || do_pop);

  // empty head reads as zero so out_* idle at 0
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: one-outstanding imem requests, buffered {pc,instr}
// to decode, redirect flush. Ports: imem_*, redirect_*, out_*.
module instr_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [PC_W-1:0]             imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [cpu_pkg::INSTR_W-1:0] imem_rdata,
  input  logic                        redirect_valid,
  input  logic [PC_W-1:0]             redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cpu_pkg::INSTR_W-1:0] out_instr,
  output logic [2:0]                  out_opcode,
  output logic [PC_W-1:0]             out_pc
);

  import cpu_pkg::*;

  localparam int EW = PC_W + INSTR_W;

  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] req_pc_n;
  logic            accept;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic [EW-1:0]   head;

  assign imem_req  = (state == FETCH) && !full && !rst;
  assign imem_addr = (state == FETCH && !rst) ? pc : '0;
  assign accept    = imem_req && imem_ready;

  assign out_valid           = !empty;
  assign {out_pc, out_instr} = head;
  assign out_opcode          = opcode_of(out_instr);
  assign pop                 = out_valid && out_ready;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    push     = 1'b0;
    flush    = 1'b0;
    unique case (state)
      FETCH: begin
        if (accept) begin
          pc_n     = pc + 1'b1;
          req_pc_n = pc;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // redirect overrides; an in-flight request
    // (even one accepted now) must be drained
    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_n  = redirect_pc;
      unique case (state)
        FETCH:       state_n = accept ? DRAIN : FETCH;
        WAIT, DRAIN: state_n = imem_rvalid ? FETCH : DRAIN;
        default:     state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({req_pc, imem_rdata}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with set latency,
// scoreboard of expected {pc,instr} popped on delivery.
module tb_instr_fetch;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [2:0]  out_opcode;
  logic [15:0] out_pc;

  logic        req2;
  logic [15:0] addr2;
  logic        v2;
  logic [15:0] instr2;
  logic [2:0]  op2;
  logic [15:0] pc2;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cnt = 0;
  int          pops = 0;
  int          cyc = 0;
  bit          stale = 1'b0;
  bit          popped = 1'b0;
  logic [15:0] pend_addr = '0;
  logic [15:0] mpc = '0;
  logic [15:0] last_pop_pc = '0;
  ent_t        sbq[$];

  bit          drv_rst = 1'b1;
  bit          drv_ready = 1'b0;
  bit          drv_oready = 1'b0;
  bit          drv_redir = 1'b0;
  logic [15:0] drv_rpc = '0;

  always #5 clk = ~clk;

  instr_fetch #(
    .PC_W     (16),
    .RESET_PC (16'h0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_pc         (out_pc)
  );

  instr_fetch #(
    .PC_W     (16),
    .RESET_PC (16'hFFFF),
    .DEPTH    (2)
  ) dut2 (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (v2),
    .out_ready      (out_ready),
    .out_instr      (instr2),
    .out_opcode     (op2),
    .out_pc         (pc2)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[2:0], a[12:0]};
  endfunction

  task automatic tick();
    ent_t e;
    bit   r;
    r = drv_redir;
    drv_redir = 1'b0;
    @(negedge clk);
    cyc++;
    rst            = drv_rst;
    imem_ready     = drv_ready;
    out_ready      = drv_oready;
    redirect_valid = r;
    redirect_pc    = drv_rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_fn(pend_addr);
      end
    end
    #1;
    popped = 1'b0;
    if (out_valid && out_ready) begin
      popped = 1'b1;
      pops++;
      last_pop_pc = out_pc;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr=%h",
                 out_pc, out_instr);
      end else begin
        e = sbq.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr ||
            out_opcode !== e.instr[15:13]) begin
          errors++;
          $display("FAIL sb_pop got %h/%h/%h exp %h/%h/%h",
                   out_pc, out_instr, out_opcode,
                   e.pc, e.instr, e.instr[15:13]);
        end
      end
    end
    if (imem_rvalid) begin
      if (!r && !stale && !drv_rst) begin
        e.pc    = pend_addr;
        e.instr = mem_fn(pend_addr);
        sbq.push_back(e);
      end
      stale = 1'b0;
    end
    if (!drv_rst && imem_req && imem_ready) begin
      checks++;
      if (imem_addr !== mpc || cnt != 0) begin
        errors++;
        $display("FAIL accept got addr=%h pend=%0d exp addr=%h pend=0",
                 imem_addr, cnt, mpc);
      end
      pend_addr = mpc;
      cnt       = lat;
      mpc       = mpc + 16'd1;
    end
    if (drv_rst) begin
      sbq.delete();
      mpc = 16'h0000;
      if (cnt > 0) stale = 1'b1;
    end else if (r) begin
      sbq.delete();
      mpc = drv_rpc;
      if (cnt > 0) stale = 1'b1;
    end
  endtask

  task automatic do_reset();
    drv_rst   = 1'b1;
    drv_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8 && cnt > 0; i++) tick();
    drv_rst   = 1'b0;
    drv_ready = 1'b1;
  endtask

  task automatic test_reset();
    drv_oready = 1'b1;
    drv_ready  = 1'b1;
    drv_rst    = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_req got %b/%h exp 0/0000",
               imem_req, imem_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0 ||
        out_pc !== 16'h0 || out_opcode !== 3'h0) begin
      errors++;
      $display("FAIL reset_out got %b/%h/%h/%h exp all 0",
               out_valid, out_instr, out_pc, out_opcode);
    end
    drv_rst = 1'b0;
  endtask

  task automatic test_stream();
    int last;
    int p0;
    lat        = 1;
    drv_oready = 1'b1;
    do_reset();
    p0   = pops;
    last = cyc + 1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL first_req got %b/%h exp 1/0000",
               imem_req, imem_addr);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (popped) begin
        checks++;
        if (cyc - last != 2) begin
          errors++;
          $display("FAIL cadence got gap %0d exp 2", cyc - last);
        end
        last = cyc;
      end
    end
    checks++;
    if (pops - p0 != 12) begin
      errors++;
      $display("FAIL stream_count got %0d exp 12", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] spc;
    logic [15:0] sins;
    int          p0;
    drv_oready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    spc  = out_pc;
    sins = out_instr;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || imem_req !== 1'b0 ||
        out_pc !== spc || out_instr !== sins) begin
      errors++;
      $display("FAIL stall got %b/%b/%h/%h exp 1/0/%h/%h",
               out_valid, imem_req, out_pc, out_instr, spc, sins);
    end
    checks++;
    if (sbq.size() != 2) begin
      errors++;
      $display("FAIL stall_occ got %0d exp 2", sbq.size());
    end
    drv_oready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (pops - p0 < 10) begin
      errors++;
      $display("FAIL release got %0d pops exp >=10", pops - p0);
    end
  endtask

  task automatic test_redirect_drain();
    bit got;
    lat        = 3;
    drv_oready = 1'b1;
    do_reset();
    tick();
    drv_redir = 1'b1;
    drv_rpc   = 16'h0040;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL drain_req got %b exp 0", imem_req);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = popped;
    end
    checks++;
    if (!got || last_pop_pc !== 16'h0040) begin
      errors++;
      $display("FAIL drain_next got %b/%h exp 1/0040",
               got, last_pop_pc);
    end
  endtask

  task automatic test_same_cycle();
    bit found;
    bit got;
    int p0;
    lat        = 1;
    drv_oready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = (cnt == 1) && out_valid;
    end
    drv_oready = 1'b1;
    drv_redir  = 1'b1;
    drv_rpc    = 16'h0100;
    p0         = pops;
    tick();
    checks++;
    if (!found || imem_rvalid !== 1'b1 || out_valid !== 1'b1 ||
        pops != p0 + 1) begin
      errors++;
      $display("FAIL same_cyc got %b/%b/%b/%0d exp 1/1/1/1",
               found, imem_rvalid, out_valid, pops - p0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 ||
        imem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL after_redir got %b/%b/%h exp 0/1/0100",
               out_valid, imem_req, imem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = popped;
    end
    checks++;
    if (!got || last_pop_pc !== 16'h0100) begin
      errors++;
      $display("FAIL same_next got %b/%h exp 1/0100",
               got, last_pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    lat        = 3;
    drv_oready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    drv_rst   = 1'b1;
    drv_ready = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL rmid_req got %b/%h exp 0/0000",
               imem_req, imem_addr);
    end
    drv_rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0 ||
        out_pc !== 16'h0 || out_opcode !== 3'h0) begin
      errors++;
      $display("FAIL rmid_out got %b/%h/%h/%h exp all 0",
               out_valid, out_instr, out_pc, out_opcode);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_late got %b exp 0", out_valid);
    end
    drv_ready  = 1'b1;
    drv_oready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = popped;
    end
    checks++;
    if (!got || last_pop_pc !== 16'h0000) begin
      errors++;
      $display("FAIL rmid_restart got %b/%h exp 1/0000",
               got, last_pop_pc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seen[$];
    lat        = 1;
    drv_oready = 1'b1;
    do_reset();
    tick();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_req got %b/%h exp 1/ffff", req2, addr2);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (v2 && out_ready) seen.push_back(pc2);
    end
    checks++;
    if (seen.size() < 2) begin
      errors++;
      $display("FAIL wrap_cnt got %0d exp >=2", seen.size());
    end else begin
      if (seen[0] !== 16'hFFFF || seen[1] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_pc got %h,%h exp ffff,0000",
                 seen[0], seen[1]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
